// File: rtl/multicycle_ctrl_if.sv
// Shared memory-port handshake between the multicycle control FSM and the memory.
// The controller drives the request side; memory answers with a one-cycle ack.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_sel_data;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_sel_data,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_sel_data,
        output mem_ack
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing on one clock,
// shared memory-port arbitration with timeout, datapath select decode and retire counting.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int RET_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   mem,
    input  logic [5:0]          opcode,
    input  logic [5:0]          func,
    input  logic                alu_zero,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic                alu_src_b,
    output logic [3:0]          alu_ctrl,
    output logic                reg_we,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic [RET_W-1:0]    retired,
    output logic [1:0]          err,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERROR  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE,
        C_ADDI,
        C_LW,
        C_SW,
        C_BEQ,
        C_J,
        C_ILLEGAL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Counter only needs to reach MEM_TIMEOUT-1: the limit is detected on the
    // last waiting cycle so that an ack arriving in that same cycle still wins.
    localparam int              TW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit              TMO_EN  = (MEM_TIMEOUT > 0);
    localparam logic [TW-1:0]   T_LIMIT = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic [TW-1:0]   T_ONE   = TW'(1);
    localparam logic [RET_W-1:0] R_ONE  = RET_W'(1);

    function automatic iclass_t decode_class(input logic [5:0] op, input logic [5:0] fn);
        iclass_t c;
        c = C_ILLEGAL;
        unique case (op)
            OP_RTYPE: begin
                if (fn == FN_ADD || fn == FN_SUB || fn == FN_AND ||
                    fn == FN_OR  || fn == FN_SLT)
                    c = C_RTYPE;
            end
            OP_ADDI: c = C_ADDI;
            OP_LW:   c = C_LW;
            OP_SW:   c = C_SW;
            OP_BEQ:  c = C_BEQ;
            OP_J:    c = C_J;
            default: c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] alu_for_func(input logic [5:0] fn);
        logic [3:0] a;
        unique case (fn)
            FN_SUB:  a = ALU_SUB;
            FN_AND:  a = ALU_AND;
            FN_OR:   a = ALU_OR;
            FN_SLT:  a = ALU_SLT;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    state_t           state_q, state_d;
    iclass_t          cls_q;
    logic [3:0]       rfn_alu_q;
    logic [1:0]       err_q, err_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [RET_W-1:0] retired_q;
    logic             retire;
    logic             tmo_hit;

    logic       req_c, we_c, sel_c;
    logic       ir_we_c, pc_we_c, alu_src_b_c;
    logic       reg_we_c, reg_dst_c, mem_to_reg_c;
    logic [1:0] pc_src_c;
    logic [3:0] alu_ctrl_c;

    assign tmo_hit = TMO_EN && (tcnt_q == T_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            err_q     <= ERR_NONE;
            tcnt_q    <= '0;
            retired_q <= '0;
            cls_q     <= C_ILLEGAL;
            rfn_alu_q <= ALU_ADD;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
            if (retire)
                retired_q <= retired_q + R_ONE;
            // IR is stable from DECODE on; capture the class once so later states need not re-decode.
            if (state_q == S_DECODE) begin
                cls_q     <= decode_class(opcode, func);
                rfn_alu_q <= alu_for_func(func);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        retire       = 1'b0;
        req_c        = 1'b0;
        we_c         = 1'b0;
        sel_c        = 1'b0;
        ir_we_c      = 1'b0;
        pc_we_c      = 1'b0;
        pc_src_c     = PC_SEQ;
        alu_src_b_c  = 1'b0;
        alu_ctrl_c   = ALU_ADD;
        reg_we_c     = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem.mem_ack) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_ERROR;
                end
            end

            S_DECODE: begin
                if (decode_class(opcode, func) == C_ILLEGAL) begin
                    err_d   = ERR_ILLEGAL;
                    state_d = S_ERROR;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                unique case (cls_q)
                    C_RTYPE: begin
                        alu_ctrl_c = rfn_alu_q;
                        state_d    = S_WB;
                    end
                    C_ADDI: begin
                        alu_src_b_c = 1'b1;
                        state_d     = S_WB;
                    end
                    C_LW, C_SW: begin
                        alu_src_b_c = 1'b1;
                        state_d     = S_MEM;
                    end
                    C_BEQ: begin
                        alu_ctrl_c = ALU_SUB;
                        if (alu_zero) begin
                            pc_we_c  = 1'b1;
                            pc_src_c = PC_BRANCH;
                        end
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_J: begin
                        pc_we_c  = 1'b1;
                        pc_src_c = PC_JUMP;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_ERROR;
                endcase
            end

            S_MEM: begin
                // Address stays on the ALU output for the whole request.
                req_c       = 1'b1;
                sel_c       = 1'b1;
                alu_src_b_c = 1'b1;
                we_c        = (cls_q == C_SW);
                if (mem.mem_ack) begin
                    if (cls_q == C_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo_hit) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_ERROR;
                end
            end

            S_WB: begin
                reg_we_c     = 1'b1;
                reg_dst_c    = (cls_q == C_RTYPE);
                mem_to_reg_c = (cls_q == C_LW);
                retire       = 1'b1;
                state_d      = S_FETCH;
            end

            S_ERROR: begin
                state_d = S_ERROR;
            end

            default: state_d = S_ERROR;
        endcase

        // Wait counter: restarts on any state change or ack, counts while a request is unanswered.
        if (state_d != state_q || mem.mem_ack || !req_c)
            tcnt_d = '0;
        else
            tcnt_d = tcnt_q + T_ONE;
    end

    // Strobes are forced low while reset is held, so nothing toggles before the first real FETCH cycle.
    assign mem.mem_req      = rst_n & req_c;
    assign mem.mem_we       = rst_n & req_c & we_c;
    assign mem.mem_sel_data = rst_n & sel_c;
    assign ir_we            = rst_n & ir_we_c;
    assign pc_we            = rst_n & pc_we_c;
    assign pc_src           = rst_n ? pc_src_c : PC_SEQ;
    assign alu_src_b        = rst_n & alu_src_b_c;
    assign alu_ctrl         = rst_n ? alu_ctrl_c : ALU_ADD;
    assign reg_we           = rst_n & reg_we_c;
    assign reg_dst          = rst_n & reg_dst_c;
    assign mem_to_reg       = rst_n & mem_to_reg_c;
    assign retired          = retired_q;
    assign err              = err_q;
    assign state            = state_q;

endmodule
